imem_fetch: RTL and testbench
=============================

Name: imem_fetch

Overview:
- Parametrised, loadable instruction memory with a handshaked fetch port. It is the next-generation instruction store for the datapath.
- A load state machine fills the array word by word from a program loader after reset. No file is read at reset.
- The fetch side accepts a PC under valid/ready and returns the instruction word one cycle later from a registered output, with range/alignment checking and flush support for taken branches.

Parameters:
- DATA_W, 32, instruction word width.
- DEPTH, 64, number of words; a power of two, at least 2.
- PC_W, 32, width of PC input.
- BYTE_ADDR, 1, 1 = PC is a byte address (word index = PC >> 2); 0 = PC is a word index.
- NOP_WORD, 0, word returned on an error response.
- Local parameter: IDX_W = $clog2(DEPTH).

Ports:
- Clk  input  1  clock.
- Reset  input  1  reset, asynchronous, active-low.
- ld_en  input  1  load write strobe; valid only in LOAD.
- ld_addr  input  IDX_W  word index to write.
- ld_data  input  DATA_W  word to write.
- ld_last  input  1  qualifies ld_en; marks the final word.
- reload  input  1  request return to LOAD from RUN.
- loading  output  1  1 while in LOAD.
- req_valid  input  1  fetch request.
- req_ready  output  1  fetch request accepted when req_valid & req_ready.
- PC  input  PC_W  fetch address.
- flush  input  1  discard the pending response.
- resp_valid  output  1  response held in output register.
- resp_ready  input  1  consumer accepts the response.
- IM  output  DATA_W  instruction word.
- resp_err  output  1  error flag for the current response.
- par_err  output  1  sticky parity error flag (see Optional Feature).

Behaviour:
- Reset (async, Reset=0):
  - state=LOAD, loading=1, req_ready=0, resp_valid=0, IM=NOP_WORD, resp_err=0, par_err=0.
  - Array contents are undefined and not cleared.
- State LOAD:
  - Each cycle with ld_en=1 writes ld_data to mem[ld_addr] on the rising edge.
  - ld_en & ld_last writes the final word, then moves to RUN on the same edge.
  - Fetch requests are ignored (req_ready=0).
  - reload is ignored.
- State RUN:
  - loading=0. ld_en is ignored, and no writes occur.
  - req_ready = !resp_valid | resp_ready | flush, i.e. the output register can accept a new word this cycle.
  - On an accepted request, the next edge loads the output register: resp_valid=1, IM=mem[idx], resp_err=0. Fetch latency is exactly 1 cycle.
  - idx = BYTE_ADDR ? PC[IDX_W+1:2] : PC[IDX_W-1:0].
  - Error cases:
    - Misaligned: BYTE_ADDR=1 and PC[1:0]!=0.
    - Out of range: any PC bit above the index field is non-zero.
    - On either error: IM=NOP_WORD, resp_err=1, resp_valid=1. The fetch is not dropped.
  - Holding: while resp_valid=1 and resp_ready=0, IM and resp_err stay stable.
  - resp_valid & resp_ready with no new request: resp_valid→0 next edge, and IM holds its last value.
- Flush:
  - flush=1 clears resp_valid next edge, unless a request is accepted in the same cycle.
  - In that case the new request's data is loaded; the post-branch fetch wins over the flush.
- Reload:
  - reload=1 in RUN moves to LOAD next edge and clears resp_valid.
  - A request in the same cycle is not accepted (req_ready forced 0 when reload=1).
- Reset asserted mid-load or mid-fetch returns the block to the reset values immediately. Any partially loaded program must be reloaded.
- Array: synchronous write, synchronous read into the output register. No combinational path from PC to IM.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each array word stores an extra even-parity bit computed from ld_data on load.
  - On fetch, a parity mismatch sets resp_err=1 for that response (IM still returns the stored data) and sets par_err=1.
  - par_err is sticky until Reset.
- Not defined: no parity storage; par_err is tied 0.

Test Plan:
- Reset, load mem[0..3]=0x11,0x22,0x33,0x44 with ld_last on index 3 → loading falls the cycle after the last write; req_ready=1.
- BYTE_ADDR=1, back-to-back requests PC=0x0,0x4,0x8 with resp_ready=1 → IM=0x11,0x22,0x33 on consecutive cycles, each one cycle after its request; resp_err=0.
- resp_ready=0 for 3 cycles after a response for PC=0xC → IM=0x44 stable, req_ready=0; releasing resp_ready re-enables req_ready in the same cycle.
- PC=0x2 (misaligned), then PC=0x100 (out of range, DEPTH=64) → IM=0, resp_err=1 on both responses, resp_valid=1.
- A pending response plus flush with no request → resp_valid=0 next cycle. Flush plus request for PC=0x4 → next IM=0x22 with resp_valid=1.
- With IMEM_PARITY_EN defined, force-corrupt one bit of mem[1] and fetch PC=0x4 → resp_err=1 and par_err=1, and par_err stays 1 after a clean fetch. Then pulse reload → loading=1 and req_ready=0.

Source files
------------

// File: rtl/imem_fetch.sv
// ============================================================================
// Module : imem_fetch
// Brief  : Loadable instruction memory with a valid/ready fetch port and a
//          registered output. Optional parity is enabled by IMEM_PARITY_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_fetch #(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 64,
    parameter int                PC_W      = 32,
    parameter bit                BYTE_ADDR = 1'b1,
    parameter logic [DATA_W-1:0] NOP_WORD  = '0,
    localparam int               IDX_W     = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              reload,
    output logic              loading,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [PC_W-1:0]   PC,
    input  logic              flush,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] IM,
    output logic              resp_err,
    output logic              par_err
);

    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

`ifdef IMEM_PARITY_EN
    localparam int c_MEM_W = DATA_W + 1;
`else
    localparam int c_MEM_W = DATA_W;
`endif

    state_t            r_state;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_im;
    logic              r_resp_err;
    logic              r_par_err;

    logic [c_MEM_W-1:0] r_mem [DEPTH];

    logic [PC_W-1:0]    w_word;
    logic [IDX_W-1:0]   w_idx;
    logic               w_misalign;
    logic               w_oor;
    logic               w_accept;
    logic               w_wr;
    logic [c_MEM_W-1:0] w_wr_word;
    logic [c_MEM_W-1:0] w_rd_word;
    logic               w_par_bad;

    // Word index is the low field of the (optionally shifted) PC; any
    // remaining high bit means the fetch falls outside the array.
    assign w_word     = BYTE_ADDR ? (PC >> 2) : PC;
    assign w_idx      = w_word[IDX_W-1:0];
    assign w_oor      = |(w_word >> IDX_W);
    assign w_misalign = BYTE_ADDR && (PC[1:0] != 2'b00);

    assign req_ready  = (r_state == S_RUN) && !reload &&
                        (!r_resp_valid || resp_ready || flush);
    assign w_accept   = req_valid && req_ready;
    assign w_wr       = (r_state == S_LOAD) && ld_en;
    assign w_rd_word  = r_mem[w_idx];

`ifdef IMEM_PARITY_EN
    assign w_wr_word  = {^ld_data, ld_data};
    assign w_par_bad  = ^w_rd_word;
`else
    assign w_wr_word  = ld_data;
    assign w_par_bad  = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (w_wr) begin
            r_mem[ld_addr] <= w_wr_word;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= S_LOAD;
            r_resp_valid <= 1'b0;
            r_im         <= NOP_WORD;
            r_resp_err   <= 1'b0;
            r_par_err    <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (ld_en && ld_last) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (reload) begin
                        r_state      <= S_LOAD;
                        r_resp_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_resp_valid <= 1'b1;
                        if (w_misalign || w_oor) begin
                            r_im       <= NOP_WORD;
                            r_resp_err <= 1'b1;
                        end else begin
                            r_im       <= w_rd_word[DATA_W-1:0];
                            r_resp_err <= w_par_bad;
                            if (w_par_bad) begin
                                r_par_err <= 1'b1;
                            end
                        end
                    end else if (flush || (r_resp_valid && resp_ready)) begin
                        r_resp_valid <= 1'b0;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign loading    = (r_state == S_LOAD);
    assign resp_valid = r_resp_valid;
    assign IM         = r_im;
    assign resp_err   = r_resp_err;
    assign par_err    = r_par_err;

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch.sv
// ============================================================================
// Module : tb_imem_fetch
// Brief  : Directed self-checking bench for imem_fetch (DEPTH=64, byte PCs).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_fetch;

    localparam int c_DATA_W = 32;
    localparam int c_DEPTH  = 64;
    localparam int c_IDX_W  = 6;
    localparam int c_PC_W   = 32;

    logic                Clk;
    logic                Reset;
    logic                ld_en;
    logic [c_IDX_W-1:0]  ld_addr;
    logic [c_DATA_W-1:0] ld_data;
    logic                ld_last;
    logic                reload;
    logic                loading;
    logic                req_valid;
    logic                req_ready;
    logic [c_PC_W-1:0]   PC;
    logic                flush;
    logic                resp_valid;
    logic                resp_ready;
    logic [c_DATA_W-1:0] IM;
    logic                resp_err;
    logic                par_err;

    int checks = 0;
    int passes = 0;

    imem_fetch #(
        .DATA_W    (c_DATA_W),
        .DEPTH     (c_DEPTH),
        .PC_W      (c_PC_W),
        .BYTE_ADDR (1'b1),
        .NOP_WORD  (32'h0)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .reload     (reload),
        .loading    (loading),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .PC         (PC),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .IM         (IM),
        .resp_err   (resp_err),
        .par_err    (par_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    logic [c_DATA_W-1:0] w_exp_par_im;
    logic                w_exp_par_err;

    initial begin
        Reset = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
        reload = 1'b0; req_valid = 1'b0; PC = '0; flush = 1'b0; resp_ready = 1'b0;
        tick();
        tick();
        chk("rst_loading",   loading,    1);
        chk("rst_req_ready", req_ready,  0);
        chk("rst_resp_valid",resp_valid, 0);
        chk("rst_IM",        IM,         0);
        chk("rst_resp_err",  resp_err,   0);
        chk("rst_par_err",   par_err,    0);
        Reset = 1'b1;
        tick();

        // Load four words; the last one carries ld_last.
        for (int i = 0; i < 4; i++) begin
            ld_en   = 1'b1;
            ld_addr = c_IDX_W'(i);
            ld_data = 32'h11 * (i + 1);
            ld_last = (i == 3);
            req_valid = 1'b1;
            #1;
            chk("load_req_ready", req_ready, 0);
            tick();
            chk("load_loading", loading, (i == 3) ? 0 : 1);
        end
        ld_en = 1'b0; ld_last = 1'b0; req_valid = 1'b0;
        #1;
        chk("run_req_ready", req_ready, 1);

        // Back-to-back fetches.
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        PC = 32'h0; tick();
        chk("b2b0_valid", resp_valid, 1); chk("b2b0_IM", IM, 32'h11); chk("b2b0_err", resp_err, 0);
        PC = 32'h4; tick();
        chk("b2b1_IM", IM, 32'h22); chk("b2b1_err", resp_err, 0);
        PC = 32'h8; tick();
        chk("b2b2_IM", IM, 32'h33); chk("b2b2_valid", resp_valid, 1);

        // Backpressure holds the response.
        PC = 32'hC; tick();
        chk("hold_IM0", IM, 32'h44);
        req_valid = 1'b0; resp_ready = 1'b0;
        #1;
        chk("hold_req_ready", req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_IM", IM, 32'h44);
            chk("hold_valid", resp_valid, 1);
            chk("hold_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        #1;
        chk("release_req_ready", req_ready, 1);
        tick();
        chk("drain_valid", resp_valid, 0);
        chk("drain_IM_hold", IM, 32'h44);

        // Misaligned and out-of-range fetches.
        req_valid = 1'b1;
        PC = 32'h2; tick();
        chk("misal_IM", IM, 0); chk("misal_err", resp_err, 1); chk("misal_valid", resp_valid, 1);
        PC = 32'h100; tick();
        chk("oor_IM", IM, 0); chk("oor_err", resp_err, 1); chk("oor_valid", resp_valid, 1);
        PC = 32'h4; tick();
        chk("recover_err", resp_err, 0); chk("recover_IM", IM, 32'h22);
        req_valid = 1'b0; tick();
        chk("idle_valid", resp_valid, 0);

        // Flush of a pending response, then flush together with a request.
        resp_ready = 1'b0;
        req_valid = 1'b1; PC = 32'h0; tick();
        chk("pend_IM", IM, 32'h11);
        req_valid = 1'b0; flush = 1'b1; tick();
        chk("flush_valid", resp_valid, 0);
        flush = 1'b0; req_valid = 1'b1; PC = 32'h8; tick();
        chk("pend2_IM", IM, 32'h33);
        flush = 1'b1; PC = 32'h4;
        #1;
        chk("flush_req_ready", req_ready, 1);
        tick();
        chk("flushreq_valid", resp_valid, 1);
        chk("flushreq_IM", IM, 32'h22);
        flush = 1'b0; resp_ready = 1'b1;

`ifdef IMEM_PARITY_EN
        dut.r_mem[1][0] = ~dut.r_mem[1][0];
        w_exp_par_im  = 32'h23;
        w_exp_par_err = 1'b1;
`else
        w_exp_par_im  = 32'h22;
        w_exp_par_err = 1'b0;
`endif
        PC = 32'h4; tick();
        chk("par_IM", IM, w_exp_par_im);
        chk("par_resp_err", resp_err, w_exp_par_err);
        chk("par_flag", par_err, w_exp_par_err);
        PC = 32'h0; tick();
        chk("par_clean_err", resp_err, 0);
        chk("par_sticky", par_err, w_exp_par_err);

        // Reload blocks the same-cycle request and returns to LOAD.
        reload = 1'b1;
        #1;
        chk("reload_req_ready", req_ready, 0);
        tick();
        chk("reload_loading", loading, 1);
        chk("reload_valid", resp_valid, 0);
        reload = 1'b0;
        #1;
        chk("reload_req_ready2", req_ready, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
